// File: rtl/fifo_reader.sv
// Drain-side controller for a synchronous FIFO with 1-cycle registered read data.
// Converts FIFO reads into a valid/ready stream through a 2-entry skid buffer.
module fifo_reader #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  flush,
  output logic                  fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  underflow_err,
  output logic [1:0]            dbg_state
);

  // Stream handshake: a word transfers on every rising edge where m_valid & m_ready;
  // once m_valid is high it stays high with m_data unchanged until that transfer.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [FIFO_WIDTH-1:0] skid0;
  logic [FIFO_WIDTH-1:0] skid1;
  logic [1:0]            occ;
  logic                  inflight;
  logic                  push;
  logic                  pop;
  logic                  clear;
  logic [2:0]            used;
  logic [2:0]            limit;

  assign m_valid   = (occ != 2'd0);
  assign m_data    = skid0;
  assign pop       = m_valid & m_ready;
  assign clear     = flush | (state == FLUSH);
  assign push      = inflight & ~fifo_underflow & ~clear;
  assign dbg_state = state;

  // A pop this cycle frees a slot, so a read may be issued against it.
  assign used  = {1'b0, occ} + {2'b00, inflight};
  assign limit = 3'd2 + {2'b00, pop};

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = FLUSH;
    end else begin
      case (state)
        IDLE:    if (enable) state_next = RUN;
        RUN:     if (!enable) state_next = IDLE;
        FLUSH:   if (fifo_empty && !inflight) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    fifo_rd_en = 1'b0;
    case (state)
      RUN:     fifo_rd_en = ~fifo_empty & (used < limit);
      FLUSH:   fifo_rd_en = ~fifo_empty;
      default: fifo_rd_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      inflight      <= 1'b0;
      occ           <= 2'd0;
      skid0         <= '0;
      skid1         <= '0;
      rd_count      <= '0;
      underflow_err <= 1'b0;
    end else begin
      state    <= state_next;
      inflight <= fifo_rd_en;
      if (fifo_underflow) underflow_err <= 1'b1;
      if (pop) rd_count <= rd_count + CNT_WIDTH'(1);
      if (clear) begin
        occ   <= 2'd0;
        skid0 <= '0;
        skid1 <= '0;
      end else begin
        case ({push, pop})
          2'b10: begin
            if (occ == 2'd0) skid0 <= fifo_data_out;
            else             skid1 <= fifo_data_out;
            occ <= occ + 2'd1;
          end
          2'b01: begin
            skid0 <= skid1;
            occ   <= occ - 2'd1;
          end
          2'b11: begin
            if (occ == 2'd1) begin
              skid0 <= fifo_data_out;
            end else begin
              skid0 <= skid1;
              skid1 <= fifo_data_out;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: a small behavioural FIFO feeds the reader,
// every observation is checked by an immediate assertion against hand-derived values.
module tb_fifo_reader;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        flush;
  logic        fifo_rd_en;
  logic [15:0] fifo_data_out = '0;
  logic        fifo_empty;
  logic        fifo_underflow;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] rd_count;
  logic        underflow_err;
  logic [1:0]  dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] exp_q[$];
  logic [15:0] mem [0:255];
  int          wr_ptr    = 0;
  int          rd_ptr    = 0;
  int          rd_issued = 0;
  bit          endless   = 1'b0;

  fifo_reader #(.FIFO_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .flush         (flush),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_data_out (fifo_data_out),
    .fifo_empty    (fifo_empty),
    .fifo_underflow(fifo_underflow),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .rd_count      (rd_count),
    .underflow_err (underflow_err),
    .dbg_state     (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIFO: registered read data, combinational empty.
  assign fifo_empty = endless ? 1'b0 : (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_data_out <= endless ? 16'hBEEF : mem[rd_ptr % 256];
      if (!endless) rd_ptr <= rd_ptr + 1;
      rd_issued <= rd_issued + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [15:0] v);
    mem[wr_ptr % 256] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin : stimulus
    logic [15:0] held_data;
    bit          held;
    int          delivered;
    int          base_issued;
    int          outstanding;
    bit          found;

    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; m_ready = 1'b0; fifo_underflow = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 16'h0000);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_count", rd_count, 16'h0000);
    check("rst_uflow", underflow_err, 0);
    check("rst_state", dbg_state, S_IDLE);

    // 1: eight preloaded words streamed back to back
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) load_word(16'(i));
    enable = 1'b1; m_ready = 1'b1;
    step();
    check("t1_state_run", dbg_state, S_RUN);
    check("t1_first_rd_en", fifo_rd_en, 1);
    check("t1_valid_c1", m_valid, 0);
    step();
    check("t1_valid_c2", m_valid, 0);
    for (int i = 1; i <= 8; i++) begin
      step();
      check("t1_valid", m_valid, 1);
      check("t1_data", m_data, 32'(i));
    end
    step();
    check("t1_valid_end", m_valid, 0);
    check("t1_rd_en_end", fifo_rd_en, 0);
    check("t1_count", rd_count, 16'd8);
    check("t1_empty", fifo_empty, 1);

    // 2: backpressure pattern 1,0,0,1 with order, hold and credit checks
    base_issued = rd_issued;
    delivered = 0;
    held = 1'b0;
    held_data = '0;
    for (int i = 0; i < 8; i++) begin
      load_word(16'h0011 + 16'(i));
      exp_q.push_back(16'h0011 + 16'(i));
    end
    for (int c = 0; c < 40; c++) begin
      m_ready = ((c % 4) == 0) || ((c % 4) == 3);
      outstanding = (rd_issued - base_issued) - delivered;
      check("t2_credit", (outstanding <= 2) ? 1 : 0, 1);
      if (held) begin
        check("t2_hold_valid", m_valid, 1);
        check("t2_hold_data", m_data, held_data);
      end
      held = 1'b0;
      if (m_valid) begin
        if (m_ready) begin
          if (exp_q.size() == 0) check("t2_extra_word", m_data, 32'hFFFF_FFFF);
          else check("t2_order", m_data, exp_q.pop_front());
          delivered++;
        end else begin
          held = 1'b1;
          held_data = m_data;
        end
      end
      step();
    end
    check("t2_all_delivered", exp_q.size(), 0);
    check("t2_count", rd_count, 16'd16);
    check("t2_valid_end", m_valid, 0);

    // 3: empty FIFO while enabled
    m_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      check("t3_rd_en", fifo_rd_en, 0);
      check("t3_valid", m_valid, 0);
    end
    check("t3_uflow", underflow_err, 0);

    // 4: deliver two words, then flush the rest
    for (int i = 0; i < 6; i++) load_word(16'h0021 + 16'(i));
    step();
    step();
    check("t4_data0", m_data, 16'h0021);
    check("t4_valid0", m_valid, 1);
    step();
    check("t4_data1", m_data, 16'h0022);
    step();
    m_ready = 1'b0; flush = 1'b1;
    check("t4_pre_flush_valid", m_valid, 1);
    step();
    flush = 1'b0; enable = 1'b0;
    check("t4_valid_after_flush", m_valid, 0);
    check("t4_state_flush", dbg_state, S_FLUSH);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      check("t4_valid_flushing", m_valid, 0);
      if (dbg_state == S_IDLE) found = 1'b1;
    end
    check("t4_back_idle", found, 1);
    check("t4_count", rd_count, 16'd18);
    check("t4_fifo_drained", fifo_empty, 1);
    check("t4_rd_en_idle", fifo_rd_en, 0);

    // 5: underflow reported during the read-return cycle
    load_word(16'h0031);
    m_ready = 1'b1; enable = 1'b1;
    step();
    check("t5_rd_en", fifo_rd_en, 1);
    step();
    fifo_underflow = 1'b1;
    step();
    fifo_underflow = 1'b0;
    check("t5_uflow_set", underflow_err, 1);
    check("t5_no_push", m_valid, 0);
    step();
    check("t5_uflow_sticky", underflow_err, 1);
    check("t5_still_no_word", m_valid, 0);
    check("t5_count", rd_count, 16'd18);

    // 6: reset with a full skid buffer, then counter wrap
    m_ready = 1'b0;
    load_word(16'h0041);
    load_word(16'h0042);
    load_word(16'h0043);
    repeat (3) step();
    check("t6_full_valid", m_valid, 1);
    check("t6_full_head", m_data, 16'h0041);
    check("t6_full_no_read", fifo_rd_en, 0);
    rst_n = 1'b0;
    step();
    check("t6_rst_valid", m_valid, 0);
    check("t6_rst_data", m_data, 16'h0000);
    check("t6_rst_rd_en", fifo_rd_en, 0);
    check("t6_rst_state", dbg_state, S_IDLE);
    check("t6_rst_count", rd_count, 16'h0000);
    check("t6_rst_uflow", underflow_err, 0);
    rst_n = 1'b1;
    endless = 1'b1;
    m_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 70000 && !found; c++) begin
      step();
      if (rd_count == 16'hFFFF) found = 1'b1;
    end
    m_ready = 1'b0;
    check("t6_reached_ffff", found, 1);
    check("t6_count_ffff", rd_count, 16'hFFFF);
    check("t6_valid_before_wrap", m_valid, 1);
    step();
    check("t6_count_held", rd_count, 16'hFFFF);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("t6_count_wrap", rd_count, 16'h0000);

    // Final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
